ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter. Sends one command byte (e.g. 8'hED set-LEDs, 8'hF4 enable) to the keyboard over the shared open-drain PS2_CLK/PS2_DAT lines, using the standard inhibit / request-to-send / device-clocked sequence. It sits beside the PS/2 keyboard receiver on the same pins. Top level muxes the pads as `pad = oe ? 1'b0 : 1'bz`, and the receiver ignores traffic while `tx_busy` is high.

---
 rtl/ps2_tx.sv | 169 ++++++++++++++++
 tb/tb_ps2_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked byte with odd parity and ACK.
// Optional build macro PS2_TX_ACK_CHECK_EN: when defined, a NACK at the 11th device clock sets tx_err.
`timescale 1ns/1ps

module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       bit_cnt, bit_cnt_d;
  logic [8:0]       shreg, shreg_d;
  logic             err, err_d;
  logic             dat_oe_d;

  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev;
  logic       clk_s, dat_s, fe;

  // Synchronizers reset to the idle-bus level so release of reset never looks like a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fe    = clk_prev & ~clk_s;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state;
    cnt_d     = cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    err_d     = err;
    dat_oe_d  = ps2_dat_oe;

    unique case (state)
      S_IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_start) begin
          shreg_d   = {~^tx_data, tx_data};
          cnt_d     = '0;
          bit_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = S_INHIBIT;
          dat_oe_d  = (INH_LAST == '0);
        end
      end

      // Data is pulled low on the last inhibit cycle so it precedes the clock release.
      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end else begin
          cnt_d    = cnt + CNT_W'(1);
          dat_oe_d = (cnt_d == INH_LAST);
        end
      end

      S_REQ, S_SEND, S_ACK, S_WAIT_IDLE: begin
        if (state == S_WAIT_IDLE && clk_s && dat_s) begin
          state_d = S_DONE;
        end else if (fe) begin
          cnt_d = '0;
          if (state == S_ACK) begin
`ifdef PS2_TX_ACK_CHECK_EN
            err_d = dat_s;
`else
            err_d = err;
`endif
            state_d = S_WAIT_IDLE;
          end else if (state == S_SEND && bit_cnt == 4'd9) begin
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end else if (state != S_WAIT_IDLE) begin
            dat_oe_d  = ~shreg[0];
            shreg_d   = {1'b0, shreg[8:1]};
            bit_cnt_d = bit_cnt + 4'd1;
            state_d   = S_SEND;
          end
        end else if (cnt == TMO_LAST) begin
          err_d    = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so the pads never see decode glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      err        <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      err        <= err_d;
      ps2_clk_oe <= (state_d == S_INHIBIT);
      ps2_dat_oe <= dat_oe_d;
      tx_busy    <= (state_d != S_IDLE);
      tx_done    <= (state_d == S_DONE);
      tx_err     <= (state_d == S_DONE) & err_d;
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a PS/2 device model clocks the host's byte out over wired-AND pads.
`timescale 1ns/1ps

module tb_ps2_tx;

  localparam int INH  = 50;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       pad_clk, pad_dat;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  assign pad_clk = dev_clk & ~ps2_clk_oe;
  assign pad_dat = dev_dat & ~ps2_dat_oe;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (pad_clk),
    .ps2_dat_in (pad_dat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (tx_done === 1'b1) done_cnt++;

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  task automatic dev_rts(output int inh_len, output int dat_first, output logic start_bit);
    inh_len   = 0;
    dat_first = -1;
    while (ps2_clk_oe === 1'b1 && inh_len < 200) begin
      inh_len++;
      if (ps2_dat_oe === 1'b1 && dat_first < 0) dat_first = inh_len;
      @(negedge clock);
    end
    start_bit = ps2_dat_oe;
  endtask

  // mode 0: plain transfer, 1: pulse tx_start during pulse 5, 2: stop mid pulse 5 with clock low
  task automatic dev_clock(input int mode, input bit ack, output logic [10:0] rx);
    rx = '0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        repeat (HALF/2) @(negedge clock);
        dev_dat = 1'b0;
        repeat (HALF/2) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      dev_clk = 1'b0;
      if (k == 5 && mode == 2) begin
        repeat (5) @(negedge clock);
        return;
      end
      if (k == 5 && mode == 1) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        repeat (HALF-1) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      if (k <= 10) rx[k-1] = pad_dat;
      dev_clk = 1'b1;
      if (k == 11) dev_dat = 1'b1;
    end
  endtask

  task automatic wait_done(output bit seen);
    int i;
    i = 0;
    while (tx_done !== 1'b1 && i < 300) begin
      @(negedge clock);
      i++;
    end
    seen = (tx_done === 1'b1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (tx_busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_cmp++; if (tx_done !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
    n_cmp++; if (tx_err !== 1'b0)     begin n_bad++; $display("FAIL reset_err: got %b want 0", tx_err); end
    n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    n_cmp++; if (ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (tx_busy !== 1'b0)    begin n_bad++; $display("FAIL idle_busy: got %b want 0", tx_busy); end
  endtask

  task automatic test_ed;
    int inh, dfirst;
    logic sb;
    logic [10:0] rx;
    bit seen;
    start_tx(8'hED);
    dev_rts(inh, dfirst, sb);
    n_cmp++; if (sb !== 1'b1) begin n_bad++; $display("FAIL ed_start_bit: got %b want 1", sb); end
    dev_clock(0, 1'b1, rx);
    n_cmp++; if (rx[7:0] !== 8'hED) begin n_bad++; $display("FAIL ed_data: got %h want ed", rx[7:0]); end
    n_cmp++; if (rx[8] !== 1'b1)    begin n_bad++; $display("FAIL ed_parity: got %b want 1", rx[8]); end
    n_cmp++; if (rx[9] !== 1'b1)    begin n_bad++; $display("FAIL ed_stop: got %b want 1", rx[9]); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)    begin n_bad++; $display("FAIL ed_done_seen: got %b want 1", seen); end
    n_cmp++; if (tx_err !== 1'b0)  begin n_bad++; $display("FAIL ed_err: got %b want 0", tx_err); end
    n_cmp++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL ed_busy_at_done: got %b want 1", tx_busy); end
    @(negedge clock);
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL ed_busy_after: got %b want 0", tx_busy); end
    n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL ed_done_width: got %b want 0", tx_done); end
  endtask

  task automatic test_f4_timing;
    int inh, dfirst;
    logic sb;
    logic [10:0] rx;
    bit seen;
    start_tx(8'hF4);
    n_cmp++; if (ps2_clk_oe !== 1'b1) begin n_bad++; $display("FAIL f4_clk_oe_rise: got %b want 1", ps2_clk_oe); end
    n_cmp++; if (tx_busy !== 1'b1)    begin n_bad++; $display("FAIL f4_busy_rise: got %b want 1", tx_busy); end
    dev_rts(inh, dfirst, sb);
    n_cmp++; if (inh !== INH)    begin n_bad++; $display("FAIL f4_inhibit_len: got %0d want %0d", inh, INH); end
    n_cmp++; if (dfirst !== INH) begin n_bad++; $display("FAIL f4_dat_oe_rise: got %0d want %0d", dfirst, INH); end
    n_cmp++; if (sb !== 1'b1)    begin n_bad++; $display("FAIL f4_start_bit: got %b want 1", sb); end
    dev_clock(0, 1'b1, rx);
    n_cmp++; if (rx[7:0] !== 8'hF4) begin n_bad++; $display("FAIL f4_data: got %h want f4", rx[7:0]); end
    n_cmp++; if (rx[8] !== 1'b0)    begin n_bad++; $display("FAIL f4_parity: got %b want 0", rx[8]); end
    n_cmp++; if (rx[9] !== 1'b1)    begin n_bad++; $display("FAIL f4_stop: got %b want 1", rx[9]); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)   begin n_bad++; $display("FAIL f4_done_seen: got %b want 1", seen); end
    n_cmp++; if (tx_err !== 1'b0) begin n_bad++; $display("FAIL f4_err: got %b want 0", tx_err); end
    @(negedge clock);
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL f4_busy_after: got %b want 0", tx_busy); end
  endtask

  task automatic test_timeout;
    int inh, dfirst, c;
    logic sb;
    start_tx(8'hED);
    dev_rts(inh, dfirst, sb);
    n_cmp++; if (sb !== 1'b1) begin n_bad++; $display("FAIL tmo_start_bit: got %b want 1", sb); end
    c = 0;
    while (tx_done !== 1'b1 && c < 3000) begin
      @(negedge clock);
      c++;
    end
    n_cmp++; if (c !== TMO)           begin n_bad++; $display("FAIL tmo_latency: got %0d want %0d", c, TMO); end
    n_cmp++; if (tx_err !== 1'b1)     begin n_bad++; $display("FAIL tmo_err: got %b want 1", tx_err); end
    n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL tmo_clk_oe: got %b want 0", ps2_clk_oe); end
    n_cmp++; if (ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL tmo_dat_oe: got %b want 0", ps2_dat_oe); end
    @(negedge clock);
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy_after: got %b want 0", tx_busy); end
  endtask

  task automatic test_nack;
    int inh, dfirst;
    logic sb, exp_err;
    logic [10:0] rx;
    bit seen;
`ifdef PS2_TX_ACK_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    start_tx(8'hED);
    dev_rts(inh, dfirst, sb);
    dev_clock(0, 1'b0, rx);
    n_cmp++; if (rx[7:0] !== 8'hED) begin n_bad++; $display("FAIL nack_data: got %h want ed", rx[7:0]); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)      begin n_bad++; $display("FAIL nack_done_seen: got %b want 1", seen); end
    n_cmp++; if (tx_err !== exp_err) begin n_bad++; $display("FAIL nack_err: got %b want %b", tx_err, exp_err); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int inh, dfirst, d0;
    logic sb;
    logic [10:0] rx;
    bit seen;
    d0 = done_cnt;
    start_tx(8'hED);
    dev_rts(inh, dfirst, sb);
    dev_clock(1, 1'b1, rx);
    n_cmp++; if (rx[7:0] !== 8'hED) begin n_bad++; $display("FAIL b2b_data: got %h want ed", rx[7:0]); end
    n_cmp++; if (rx[8] !== 1'b1)    begin n_bad++; $display("FAIL b2b_parity: got %b want 1", rx[8]); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)   begin n_bad++; $display("FAIL b2b_done_seen: got %b want 1", seen); end
    n_cmp++; if (tx_err !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b want 0", tx_err); end
    repeat (100) @(negedge clock);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (tx_busy !== 1'b0)    begin n_bad++; $display("FAIL b2b_idle_busy: got %b want 0", tx_busy); end
    n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_clk_oe: got %b want 0", ps2_clk_oe); end
  endtask

  task automatic test_reset_mid;
    int inh, dfirst, d0;
    logic sb;
    logic [10:0] rx;
    bit seen;
    d0 = done_cnt;
    start_tx(8'hED);
    dev_rts(inh, dfirst, sb);
    dev_clock(2, 1'b1, rx);
    n_cmp++; if (ps2_dat_oe !== 1'b1) begin n_bad++; $display("FAIL rst_mid_d4: got %b want 1", ps2_dat_oe); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL rst_async_dat_oe: got %b want 0", ps2_dat_oe); end
    n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL rst_async_clk_oe: got %b want 0", ps2_clk_oe); end
    n_cmp++; if (tx_busy !== 1'b0)    begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", tx_busy); end
    @(negedge clock);
    reset_n = 1'b1;
    dev_clk = 1'b1;
    repeat (100) @(negedge clock);
    n_cmp++; if (done_cnt !== d0)  begin n_bad++; $display("FAIL rst_no_done: got %0d want %0d", done_cnt, d0); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %b want 0", tx_busy); end
    start_tx(8'hED);
    dev_rts(inh, dfirst, sb);
    dev_clock(0, 1'b1, rx);
    n_cmp++; if (rx[7:0] !== 8'hED) begin n_bad++; $display("FAIL rst_retry_data: got %h want ed", rx[7:0]); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1)   begin n_bad++; $display("FAIL rst_retry_done: got %b want 1", seen); end
    n_cmp++; if (tx_err !== 1'b0) begin n_bad++; $display("FAIL rst_retry_err: got %b want 0", tx_err); end
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_ed();
    test_f4_timing();
    test_timeout();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
